// File: rtl/im_pkg.sv
// Shared definitions for the instruction memory controller.
// Holds the sequencer state type, the fetch-result source type, default
// geometry constants and small constant/helper functions used by im_ctrl.
package im_pkg;

    // Default geometry of the instruction memory
    localparam int IM_DATA_W_DEFAULT = 32;
    localparam int IM_ADDR_W_DEFAULT = 32;
    localparam int IM_DEPTH_DEFAULT  = 128;

    // Sequencer states: CLEAR wipes the array after reset, RUN is normal operation
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Where the registered fetch result currently comes from
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_BYP  = 2'd2
    } fetch_sel_t;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // A byte address is in range when its word address is below depth
    function automatic logic in_range(input logic [63:0] addr, input int depth, input int off_w);
        logic [63:0] lim;
        lim = 64'(depth);
        return (addr >> off_w) < lim;
    endfunction

endpackage

// File: rtl/im_ram.sv
// Plain DEPTH x DATA_W storage array for the instruction memory.
// One synchronous write port and one synchronous read port, no reset.
// The read register only updates when re_i is high, so it holds its value
// otherwise; a read and write to the same word in one cycle returns old data.
// Ports:
//   clk      clock
//   we_i     write enable
//   waddr_i  write word index
//   wdata_i  write data
//   re_i     read enable
//   raddr_i  read word index
//   rdata_o  registered read data
module im_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = 7
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port and enabled read register share the same clock edge
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/im_ctrl.sv
// Instruction memory controller: registered fetch port for the IF stage and
// a handshaked load port for the boot/debug loader. After reset the array is
// cleared one word per cycle; loads and fetches are blocked until that ends.
// Adds range checking, write-first bypass, stall hold and a load counter.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   if_en, if_stall       fetch request, pipeline stall (holds fetch outputs)
//   if_addr               fetch byte address
//   if_data, if_valid     fetched word, fresh-result flag
//   if_err                last fetch address was out of range
//   ld_valid, ld_ready    load handshake
//   ld_addr, ld_data      load byte address and word
//   ld_err                one-cycle pulse for a dropped out-of-range load
//   ld_count              accepted in-range loads since reset (saturating)
//   busy                  clear sequence in progress
module im_ctrl import im_pkg::*; #(
    parameter int  DATA_W = IM_DATA_W_DEFAULT,
    parameter int  ADDR_W = IM_ADDR_W_DEFAULT,
    parameter int  DEPTH  = IM_DEPTH_DEFAULT,
    localparam int OFF_W  = clog2(DATA_W / 8),
    localparam int IDX_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_en,
    input  logic              if_stall,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_valid,
    output logic              if_err,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_err,
    output logic [IDX_W:0]    ld_count,
    output logic              busy
);

    localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH - 1);

    state_t            state_q,   state_d;
    logic [IDX_W-1:0]  clrIdx_q,  clrIdx_d;
    fetch_sel_t        sel_q,     sel_d;
    logic [DATA_W-1:0] bypData_q, bypData_d;
    logic              ifValid_q, ifValid_d;
    logic              ifErr_q,   ifErr_d;
    logic              ldErr_q,   ldErr_d;
    logic [IDX_W:0]    ldCount_q, ldCount_d;

    logic [IDX_W-1:0]  ifIdx;
    logic [IDX_W-1:0]  ldIdx;
    logic              ifInRange;
    logic              ldInRange;
    logic              running;
    logic              clearing;
    logic              ldFire;
    logic              ldWrite;
    logic              fetchFire;
    logic              bypassHit;
    logic              ramWe;
    logic [IDX_W-1:0]  ramWaddr;
    logic [DATA_W-1:0] ramWdata;
    logic              ramRe;
    logic [DATA_W-1:0] ramRdata;

    // Address decode and handshake qualifiers. A bypass hit is a fetch that
    // lands on the very word being written this edge; it takes ld_data
    // directly instead of reading the array.
    assign ifIdx     = if_addr[OFF_W+IDX_W-1:OFF_W];
    assign ldIdx     = ld_addr[OFF_W+IDX_W-1:OFF_W];
    assign ifInRange = in_range(64'(if_addr), DEPTH, OFF_W);
    assign ldInRange = in_range(64'(ld_addr), DEPTH, OFF_W);
    assign running   = (state_q == RUN);
    assign clearing  = (state_q == CLEAR) && !rst;
    assign ldFire    = ld_valid && running;
    assign ldWrite   = ldFire && ldInRange;
    assign fetchFire = running && if_en && !if_stall;
    assign bypassHit = ldWrite && fetchFire && ifInRange && (ldIdx == ifIdx);

    // The clear sequencer owns the write port while clearing
    assign ramWe    = clearing ? 1'b1     : ldWrite;
    assign ramWaddr = clearing ? clrIdx_q : ldIdx;
    assign ramWdata = clearing ? '0       : ld_data;
    assign ramRe    = fetchFire && ifInRange && !bypassHit;

    im_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ramWe),
        .waddr_i (ramWaddr),
        .wdata_i (ramWdata),
        .re_i    (ramRe),
        .raddr_i (ifIdx),
        .rdata_o (ramRdata)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clrIdx_q  <= '0;
            sel_q     <= SEL_ZERO;
            bypData_q <= '0;
            ifValid_q <= 1'b0;
            ifErr_q   <= 1'b0;
            ldErr_q   <= 1'b0;
            ldCount_q <= '0;
        end else begin
            state_q   <= state_d;
            clrIdx_q  <= clrIdx_d;
            sel_q     <= sel_d;
            bypData_q <= bypData_d;
            ifValid_q <= ifValid_d;
            ifErr_q   <= ifErr_d;
            ldErr_q   <= ldErr_d;
            ldCount_q <= ldCount_d;
        end
    end

    // Next-state logic. Fetch result sources are remembered in sel_q so the
    // stall/idle hold simply keeps the selector and the RAM read register.
    always_comb begin
        state_d   = state_q;
        clrIdx_d  = clrIdx_q;
        sel_d     = sel_q;
        bypData_d = bypData_q;
        ifValid_d = ifValid_q;
        ifErr_d   = ifErr_q;
        ldErr_d   = 1'b0;
        ldCount_d = ldCount_q;

        case (state_q)
            CLEAR: begin
                ifValid_d = 1'b0;
                clrIdx_d  = clrIdx_q + 1'b1;
                if (clrIdx_q == CLR_LAST) begin
                    state_d  = RUN;
                    clrIdx_d = '0;
                end
            end
            RUN: begin
                if (ldFire) begin
                    if (ldInRange) begin
                        if (ldCount_q != '1) begin
                            ldCount_d = ldCount_q + 1'b1;
                        end
                    end else begin
                        ldErr_d = 1'b1;
                    end
                end
                if (!if_stall) begin
                    if (if_en) begin
                        ifValid_d = 1'b1;
                        if (!ifInRange) begin
                            sel_d   = SEL_ZERO;
                            ifErr_d = 1'b1;
                        end else if (bypassHit) begin
                            sel_d     = SEL_BYP;
                            bypData_d = ld_data;
                            ifErr_d   = 1'b0;
                        end else begin
                            sel_d   = SEL_RAM;
                            ifErr_d = 1'b0;
                        end
                    end else begin
                        ifValid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Fetch data is chosen from registered sources only
    always_comb begin
        case (sel_q)
            SEL_RAM: if_data = ramRdata;
            SEL_BYP: if_data = bypData_q;
            default: if_data = '0;
        endcase
    end

    assign if_valid = ifValid_q;
    assign if_err   = ifErr_q;
    assign ld_ready = running;
    assign ld_err   = ldErr_q;
    assign ld_count = ldCount_q;
    assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_im_ctrl.sv
// Directed testbench for im_ctrl at default parameters (32-bit words,
// 32-bit addresses, 128 words). Expected values are hand-computed constants.
module tb_im_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 128;
    localparam int IDX_W  = 7;

    logic              clk;
    logic              rst;
    logic              if_en;
    logic              if_stall;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic              if_valid;
    logic              if_err;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_err;
    logic [IDX_W:0]    ld_count;
    logic              busy;

    int errors = 0;
    int checks = 0;

    im_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_en    (if_en),
        .if_stall (if_stall),
        .if_addr  (if_addr),
        .if_data  (if_data),
        .if_valid (if_valid),
        .if_err   (if_err),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_err   (ld_err),
        .ld_count (ld_count),
        .busy     (busy)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [ADDR_W-1:0] a);
        if_en   = 1'b1;
        if_addr = a;
        tick();
        if_en   = 1'b0;
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    // Counts edges until busy falls (bounded); also notes any ld_ready high
    task automatic wait_clear(output int cycles, output logic readySeen);
        cycles    = 0;
        readySeen = 1'b0;
        while (busy === 1'b1 && cycles < 300) begin
            if (ld_ready !== 1'b0) readySeen = 1'b1;
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        int   n;
        logic rdy;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 1", busy); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ld_ready: got %0b expected 0", ld_ready); end
        checks++; if (if_valid !== 1'b0 || if_err !== 1'b0 || ld_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got valid=%0b err=%0b lderr=%0b expected 0 0 0", if_valid, if_err, ld_err); end
        checks++; if (if_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_if_data: got %h expected 00000000", if_data); end
        checks++; if (ld_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_ld_count: got %0d expected 0", ld_count); end
        rst = 1'b0;
        wait_clear(n, rdy);
        checks++; if (n !== 128) begin errors++; $display("[TB] FAIL clear_cycles: got %0d expected 128", n); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL clear_ld_ready_low: got %0b expected 0", rdy); end
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL run_ld_ready: got %0b expected 1", ld_ready); end
        do_fetch(32'h0);
        checks++; if (if_data !== 32'h0 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_cleared_0: got %h/%0b expected 00000000/1", if_data, if_valid); end
        do_fetch(32'h1FC);
        checks++; if (if_data !== 32'h0 || if_valid !== 1'b1 || if_err !== 1'b0) begin errors++; $display("[TB] FAIL fetch_cleared_1fc: got %h/%0b/%0b expected 00000000/1/0", if_data, if_valid, if_err); end
    endtask

    task automatic test_load_fetch();
        do_load(32'h20, 32'hDEADBEEF);
        do_load(32'h24, 32'h12345678);
        do_fetch(32'h20);
        checks++; if (if_data !== 32'hDEADBEEF || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_20: got %h/%0b expected deadbeef/1", if_data, if_valid); end
        do_fetch(32'h24);
        checks++; if (if_data !== 32'h12345678) begin errors++; $display("[TB] FAIL fetch_24: got %h expected 12345678", if_data); end
        checks++; if (ld_count !== 8'd2) begin errors++; $display("[TB] FAIL ld_count_2: got %0d expected 2", ld_count); end
    endtask

    task automatic test_bypass();
        ld_valid = 1'b1; ld_addr = 32'h40; ld_data = 32'hCAFEF00D;
        if_en    = 1'b1; if_addr = 32'h40;
        tick();
        ld_valid = 1'b0; if_en = 1'b0;
        checks++; if (if_data !== 32'hCAFEF00D || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL bypass_data: got %h/%0b expected cafef00d/1", if_data, if_valid); end
        checks++; if (ld_count !== 8'd3) begin errors++; $display("[TB] FAIL bypass_ld_count: got %0d expected 3", ld_count); end
        tick();
        checks++; if (if_valid !== 1'b0 || if_data !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL idle_hold: got %h/%0b expected cafef00d/0", if_data, if_valid); end
        do_fetch(32'h40);
        checks++; if (if_data !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL bypass_written: got %h expected cafef00d", if_data); end
    endtask

    task automatic test_range_errors();
        do_load(32'h200, 32'h1);
        checks++; if (ld_err !== 1'b1) begin errors++; $display("[TB] FAIL ld_err_pulse: got %0b expected 1", ld_err); end
        checks++; if (ld_count !== 8'd3) begin errors++; $display("[TB] FAIL ld_err_count: got %0d expected 3", ld_count); end
        tick();
        checks++; if (ld_err !== 1'b0) begin errors++; $display("[TB] FAIL ld_err_clear: got %0b expected 0", ld_err); end
        do_fetch(32'h200);
        checks++; if (if_err !== 1'b1 || if_data !== 32'h0 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_oor: got err=%0b data=%h valid=%0b expected 1 00000000 1", if_err, if_data, if_valid); end
        do_fetch(32'h20);
        checks++; if (if_err !== 1'b0 || if_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL fetch_after_oor: got err=%0b data=%h expected 0 deadbeef", if_err, if_data); end
    endtask

    task automatic test_stall();
        do_fetch(32'h20);
        checks++; if (if_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL stall_pre: got %h expected deadbeef", if_data); end
        if_stall = 1'b1; if_en = 1'b1; if_addr = 32'h24;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (if_data !== 32'hDEADBEEF || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold_%0d: got %h/%0b expected deadbeef/1", i, if_data, if_valid); end
        end
        if_stall = 1'b0;
        tick();
        if_en = 1'b0;
        checks++; if (if_data !== 32'h12345678 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_release: got %h/%0b expected 12345678/1", if_data, if_valid); end
    endtask

    task automatic test_back_to_back();
        ld_valid = 1'b1; ld_addr = 32'h44; ld_data = 32'h55AA55AA;
        if_en    = 1'b1; if_addr = 32'h20;
        tick();
        checks++; if (if_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL b2b_a: got %h expected deadbeef", if_data); end
        ld_addr = 32'h48; ld_data = 32'h0F0F0F0F; if_addr = 32'h24;
        tick();
        ld_valid = 1'b0;
        checks++; if (if_data !== 32'h12345678) begin errors++; $display("[TB] FAIL b2b_b: got %h expected 12345678", if_data); end
        if_addr = 32'h44;
        tick();
        checks++; if (if_data !== 32'h55AA55AA) begin errors++; $display("[TB] FAIL b2b_c: got %h expected 55aa55aa", if_data); end
        if_addr = 32'h48;
        tick();
        if_en = 1'b0;
        checks++; if (if_data !== 32'h0F0F0F0F || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_d: got %h/%0b expected 0f0f0f0f/1", if_data, if_valid); end
        checks++; if (ld_count !== 8'd5) begin errors++; $display("[TB] FAIL b2b_ld_count: got %0d expected 5", ld_count); end
    endtask

    task automatic test_reset_mid();
        int   n;
        logic rdy;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (50) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_clear_busy: got %0b expected 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b1 || ld_count !== 8'd0 || if_data !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_clear_reset: got busy=%0b cnt=%0d data=%h valid=%0b expected 1 0 00000000 0", busy, ld_count, if_data, if_valid); end
        wait_clear(n, rdy);
        checks++; if (n !== 128 || rdy !== 1'b0) begin errors++; $display("[TB] FAIL restart_clear: got cycles=%0d ready_seen=%0b expected 128 0", n, rdy); end
        do_fetch(32'h20);
        checks++; if (if_data !== 32'h0 || if_valid !== 1'b1) begin errors++; $display("[TB] FAIL restart_fetch_20: got %h/%0b expected 00000000/1", if_data, if_valid); end
        do_load(32'h20, 32'hDEADBEEF);
        do_load(32'h24, 32'h12345678);
        do_fetch(32'h20);
        checks++; if (if_data !== 32'hDEADBEEF || ld_count !== 8'd2) begin errors++; $display("[TB] FAIL reload: got %h cnt=%0d expected deadbeef 2", if_data, ld_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b1 || ld_ready !== 1'b0 || ld_count !== 8'd0 || if_data !== 32'h0 || if_err !== 1'b0) begin errors++; $display("[TB] FAIL run_reset: got busy=%0b rdy=%0b cnt=%0d data=%h err=%0b expected 1 0 0 00000000 0", busy, ld_ready, ld_count, if_data, if_err); end
        wait_clear(n, rdy);
        checks++; if (n !== 128 || rdy !== 1'b0) begin errors++; $display("[TB] FAIL run_reset_clear: got cycles=%0d ready_seen=%0b expected 128 0", n, rdy); end
        do_fetch(32'h20);
        checks++; if (if_data !== 32'h0) begin errors++; $display("[TB] FAIL run_reset_fetch_20: got %h expected 00000000", if_data); end
    endtask

    task automatic test_saturation();
        ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'hA5A5A5A5;
        repeat (254) tick();
        checks++; if (ld_count !== 8'd254) begin errors++; $display("[TB] FAIL sat_254: got %0d expected 254", ld_count); end
        tick();
        checks++; if (ld_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_255: got %0d expected 255", ld_count); end
        repeat (3) tick();
        ld_valid = 1'b0;
        checks++; if (ld_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 255", ld_count); end
    endtask

    // Scenario sequence
    initial begin
        rst      = 1'b1;
        if_en    = 1'b0;
        if_stall = 1'b0;
        if_addr  = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        #1;
        test_reset();
        test_load_fetch();
        test_bypass();
        test_range_errors();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
